// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule and round sequencer.
// Loads a 512-bit block, emits W[t] once per enabled RUN cycle through a
// 16-word sliding window, and drives the working-register load strobe.
// Optional build macro SHA_WK_PREADD_EN: w_out carries W[t]+K[t] instead of W[t].
module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         en,
  output logic         busy,
  output logic         control,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   round,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

`ifdef SHA_WK_PREADD_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  state_t      state_q, state_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [5:0]  round_q, round_d;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window slot 15 after the shift holds W[t+16], built from W[t+14], W[t+9], W[t+1], W[t].
  assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  // Next-state, window shift and round counter.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < 16; k++) begin
            w_d[k] = block_in[32*(15-k) +: 32];
          end
          round_d = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (en) begin
          for (int unsigned k = 0; k < 15; k++) begin
            w_d[k] = w_q[k+1];
          end
          w_d[15] = w_new;
          if (round_q == LAST_ROUND) begin
            round_d = '0;
            state_d = S_DONE;
          end else begin
            round_d = round_q + 6'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, schedule window and round registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '{default: '0};
      round_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign control = (state_q == S_INIT);
  assign w_valid = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign round   = round_q;
`ifdef SHA_WK_PREADD_EN
  assign w_out   = w_q[0] + K[round_q];
`else
  assign w_out   = w_q[0];
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: directed "abc" block plus random
// blocks, stalls, start-while-busy and mid-run reset, against a flat
// 64-word FIPS 180-4 expansion model. Honours SHA_WK_PREADD_EN.
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst, start, en;
  logic [511:0] block_in;
  logic         busy, control, w_valid, done;
  logic [31:0]  w_out;
  logic [5:0]   round;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_w [64];
  logic [31:0] cap   [64];

`ifdef SHA_WK_PREADD_EN
  logic [31:0] k_tb [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .en       (en),
    .busy     (busy),
    .control  (control),
    .w_valid  (w_valid),
    .w_out    (w_out),
    .round    (round),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain FIPS 180-4 expansion of the whole block into W[0..63].
  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = b[511 - 32*t -: 32];
      else exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endtask

  function automatic logic [31:0] exp_out(input int t);
`ifdef SHA_WK_PREADD_EN
    return exp_w[t] + k_tb[t];
`else
    return exp_w[t];
`endif
  endfunction

  function automatic logic [31:0] ref_k(input int t);
`ifdef SHA_WK_PREADD_EN
    return k_tb[t];
`else
    return (t < 0) ? 32'h1 : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] outs_vec();
    return {25'd0, busy, control, w_valid, done, 3'd0} | {26'd0, round};
  endfunction

  // One block from start to done (or to an injected reset).
  task automatic run_block(input logic [511:0] blk, input int init_hold,
                           input int stall_at, input int stall_len,
                           input int start_at, input int rst_at, input bit start_in_done);
    int idx, valid_en, stall_left;
    bit finished, injected, seen_done;
    build_model(blk);
    idx = 0; valid_en = 0; stall_left = stall_len; finished = 0; injected = 0;
    @(negedge clk);
    block_in = blk; start = 1'b1; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("init_control", 32'(control), 32'd1);
    check("init_wvalid", 32'(w_valid), 32'd0);
    check("init_busy", 32'(busy), 32'd1);
    en = (init_hold == 0);
    for (int i = 0; i < init_hold; i++) begin
      @(negedge clk);
      check("init_hold_control", 32'(control), 32'd1);
      if (i == init_hold - 1) en = 1'b1;
    end
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      block_in = blk;
      if (w_valid) begin
        check("round", 32'(round), 32'(idx));
        check("w_out", w_out, exp_out(idx));
        check("run_control", 32'(control), 32'd0);
        if (idx < 64) cap[idx] = w_out;
        if (rst_at >= 0 && idx == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_outputs", outs_vec(), 32'd0);
          check("rst_w_out", w_out, ref_k(0));
          seen_done = 0;
          repeat (ROUNDS + 8) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
          end
          check("rst_no_done", 32'(seen_done), 32'd0);
          return;
        end
        if (stall_left > 0 && idx == stall_at) begin
          en = 1'b0;
          stall_left--;
        end else begin
          en = 1'b1;
          valid_en++;
          idx++;
        end
        if (start_at >= 0 && idx == start_at && !injected) begin
          start = 1'b1;
          block_in = ~blk;
          injected = 1;
        end
      end else if (done) begin
        check("done_control", 32'(control), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_round", 32'(round), 32'd0);
        check("valid_en_count", 32'(valid_en), 32'(ROUNDS));
        start = start_in_done;
        en = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;
        check("after_done_idle", outs_vec(), 32'd0);
        @(negedge clk);
        check("done_start_ignored", outs_vec(), 32'd0);
        en = 1'b1;
        finished = 1;
      end else begin
        check("unexpected_state", outs_vec(), {25'd0, 4'b1010, 3'd0} | {26'd0, round});
        finished = 1;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
  endtask

  logic [511:0] abc;
  logic [511:0] rnd;

  initial begin
    abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    rst = 1'b1; start = 1'b0; en = 1'b0; block_in = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_vec(), 32'd0);
    check("reset_w_out", w_out, ref_k(0));
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", outs_vec(), 32'd0);
    end

    run_block(abc, 0, -1, 0, -1, -1, 1'b0);
    check("abc_W0", cap[0], 32'h61626380 + ref_k(0));
    check("abc_W1", cap[1], 32'h00000000 + ref_k(1));
    check("abc_W14", cap[14], 32'h00000000 + ref_k(14));
    check("abc_W15", cap[15], 32'h00000018 + ref_k(15));
    check("abc_W16", cap[16], 32'h61626380 + ref_k(16));
    check("abc_W17", cap[17], 32'h000F0000 + ref_k(17));

    run_block(abc, 2, 20, 3, -1, -1, 1'b0);
    run_block(abc, 0, -1, 0, 10, -1, 1'b1);
    run_block(abc, 0, -1, 0, -1, 30, 1'b0);
    run_block(abc, 0, -1, 0, -1, -1, 1'b0);
    check("abc_after_rst_W0", cap[0], 32'h61626380 + ref_k(0));

    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 16; j++) rnd[32*j +: 32] = $urandom;
      run_block(rnd, $urandom_range(0, 2), $urandom_range(0, ROUNDS - 1),
                $urandom_range(0, 4), $urandom_range(1, ROUNDS - 2), -1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Upstream of the SHA-256 working-variable registers (a..h) and the T1 adder.
- Accepts one 512-bit message block and generates the expanded message word W[t] for every compression round.
- Sequences the rounds and drives the shared `control` line. A high `control` makes every working register load its intermediate hash value; a low one advances the round.
- Runs one round per enabled clock; signals completion so the hash-update stage can add the working registers into H0..H7.

Parameters:
- ROUNDS, 64, number of compression rounds emitted; legal range 16..64 (values below 64 for reduced-round test builds only).

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request to process block_in; sampled only in IDLE.
- block_in, input, 512, message block; word 0 = block_in[511:480], word 15 = block_in[31:0].
- en, input, 1, round advance enable; low freezes all state in INIT/RUN.
- busy, output, 1, high in INIT, RUN, DONE.
- control, output, 1, high only in INIT; downstream working registers load H0..H7.
- w_valid, output, 1, high in RUN.
- w_out, output, 32, W[t] for the current round (or W[t]+K[t], see Optional Feature).
- round, output, 6, current round index t.
- done, output, 1, one-cycle pulse after the last round.

Behaviour:
- Reset: state=IDLE, all 16 schedule registers=0, round=0, busy=0, control=0, w_valid=0, done=0. w_out=0 because it reflects reg[0].
- Reset mid-operation: abort immediately to the reset state; no done pulse is produced.
- State machine: IDLE -> INIT -> RUN -> DONE -> IDLE.
- IDLE, start=1:
  - Latch block_in into reg[0..15], with reg[k]=word k.
  - Set round=0 and go to INIT.
  - start=0 holds IDLE.
- Start outside IDLE: ignored, never queued.
- INIT:
  - control=1 for one cycle, so the working registers load H.
  - If en=1, go to RUN; if en=0, stay in INIT with control held high.
- RUN, en=1:
  - Outputs: w_out=reg[0] (=W[round]), w_valid=1.
  - On the clock edge, shift reg[k] <= reg[k+1] for k=0..14.
  - Load reg[15] <= s1(reg[14]) + reg[9] + s0(reg[1]) + reg[0], mod 2^32.
  - round <= round+1.
  - When round==ROUNDS-1, go to DONE and set round to 0.
- RUN, en=0: registers, round and w_valid hold; no advance. The downstream stage must also gate on en.
- Schedule functions:
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit wrap-around; carries are discarded.
- DONE:
  - done=1, w_valid=0, control=0 for exactly one cycle, independent of en.
  - Then go to IDLE.
  - A start in that cycle is ignored; start is accepted on the following cycle.
- Latency: start accepted at edge N; control high cycle N+1; W[0] valid cycle N+2 (en held high); done at cycle N+2+ROUNDS.
- Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SHA_WK_PREADD_EN.
- Defined:
  - Include a 64-entry round-constant ROM K[0..63] (FIPS 180-4 values).
  - w_out = reg[0] + K[round], mod 2^32.
  - This removes one adder from the downstream T1 path, which then must not add K.
- Undefined: no ROM; w_out = reg[0] (raw W[t]); the downstream stage adds K.
- The port list is identical in both builds.

Test Plan:
- Reset/idle: hold rst 2 cycles, then start=0 for 10 cycles -> busy=0, control=0, w_valid=0, done=0, round=0 throughout.
- "abc" block:
  - Stimulus: block_in = 0x61626380, then 14 zero words, then 0x00000018; start pulse with en=1.
  - Control: control=1 for exactly 1 cycle.
  - Early words: W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Expanded words: W16=0x61626380, W17=0x000F0000.
  - Count and completion: 64 w_valid cycles, then a single done pulse.
- Stall: same block, deassert en for 3 cycles at round 20 -> w_out/round frozen, total w_valid-high cycles with en=1 still 64, W values unchanged vs the unstalled run.
- Start while busy: pulse start with a different block_in at round 10 -> ignored; the remaining W match the original block; only one done.
- Reset mid-run: assert rst at round 30 -> next cycle IDLE, all outputs 0, no done; a subsequent start reproduces the "abc" sequence from W0.
- Build with SHA_WK_PREADD_EN on the "abc" block -> round 0 w_out=0xA3EC9318 (0x61626380+0x428A2F98); round 1 w_out=0x71374491 (0+K1).
